muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq_pkg.sv | 37 +++
 rtl/muldiv_seq_if.sv | 13 +
 rtl/muldiv_seq.sv | 152 +++++++++++++++
 tb/tb_muldiv_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared types and constants for the SPC700 MUL/DIV sequencer: states, op encoding,
// datapath sub-op codes and the saturating helper used by the optional statistics.
package spc700;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STEP,
    ST_READ,
    ST_FIN
  } state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  localparam logic [3:0] SECOP_LOAD = 4'b0000;
  localparam logic [3:0] SECOP_MUL  = 4'b1110;
  localparam logic [3:0] SECOP_DIV  = 4'b1111;

  // Counter value seen on the last STEP edge (8 MUL steps, 9 DIV steps).
  localparam logic [3:0] MUL_LAST = 4'd7;
  localparam logic [3:0] DIV_LAST = 4'd8;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic h;
  } flags_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Link between the MUL/DIV sequencer and the external multiply/divide datapath,
// used where the two blocks are wired side by side.
interface muldiv_seq_if;
  logic        md_en;
  logic [3:0]  md_secop;
  logic [15:0] md_res;
  logic        md_zo;
  logic        md_vo;
  logic        md_ho;

  modport master (output md_en, md_secop, input md_res, md_zo, md_vo, md_ho);
  modport slave  (input md_en, md_secop, output md_res, md_zo, md_vo, md_ho);
endinterface

// File: rtl/muldiv_seq.sv
// SPC700 MUL YA / DIV YA,X sequencer: steps an external datapath and latches result/flags.
// Optional SPC_MULDIV_STAT_EN adds saturating MUL_CNT/DIV_CNT completion counters.
module muldiv_seq
  import spc700::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        START,
  input  logic        OP,
  input  logic [7:0]  A,
  input  logic [7:0]  X,
  input  logic [7:0]  Y,
  output logic        MD_EN,
  output logic [3:0]  MD_SECOP,
  input  logic [15:0] MD_RES,
  input  logic        MD_ZO,
  input  logic        MD_VO,
  input  logic        MD_HO,
  output logic        BUSY,
  output logic        DONE,
  output logic [7:0]  RES_A,
  output logic [7:0]  RES_Y,
  output logic        FLAG_N,
  output logic        FLAG_Z,
  output logic        FLAG_V,
  output logic        FLAG_H,
  output logic        FLAG_VH_WE
`ifdef SPC_MULDIV_STAT_EN
  ,
  output logic [15:0] MUL_CNT,
  output logic [15:0] DIV_CNT
`endif
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] res_q, res_d;
  flags_t      flg_q, flg_d;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    flg_d    = flg_q;
    MD_EN    = 1'b0;
    MD_SECOP = SECOP_LOAD;
    unique case (state_q)
      ST_IDLE: if (EN && START) begin
        state_d = ST_LOAD;
        op_d    = op_e'(OP);
      end
      ST_LOAD: begin
        MD_EN = EN;
        if (EN) begin
          cnt_d   = 4'd0;
          state_d = ST_STEP;
          if (op_q == OP_DIV) flg_d.h = MD_HO;
        end
      end
      ST_STEP: begin
        MD_EN    = EN;
        MD_SECOP = (op_q == OP_DIV) ? SECOP_DIV : SECOP_MUL;
        if (EN) begin
          cnt_d = cnt_q + 4'd1;
          if (op_q == OP_MUL && cnt_q == MUL_LAST) begin
            res_d   = MD_RES;
            flg_d.z = MD_ZO;
            flg_d.n = MD_RES[15];
            state_d = ST_FIN;
          end else if (op_q == OP_DIV && cnt_q == DIV_LAST) begin
            state_d = ST_READ;
          end
        end
      end
      // Datapath holds the quotient/remainder after the last step; read without stepping.
      ST_READ: begin
        MD_SECOP = SECOP_DIV;
        if (EN) begin
          res_d   = MD_RES;
          flg_d.z = MD_ZO;
          flg_d.v = MD_VO;
          flg_d.n = MD_RES[7];
          state_d = ST_FIN;
        end
      end
      ST_FIN: if (EN) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= 4'd0;
      res_q   <= 16'd0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  assign BUSY       = (state_q != ST_IDLE);
  assign DONE       = (state_q == ST_FIN);
  assign FLAG_VH_WE = DONE && (op_q == OP_DIV);
  assign RES_A      = res_q[7:0];
  assign RES_Y      = res_q[15:8];
  assign FLAG_N     = flg_q.n;
  assign FLAG_Z     = flg_q.z;
  assign FLAG_V     = flg_q.v;
  assign FLAG_H     = flg_q.h;

`ifdef SPC_MULDIV_STAT_EN
  logic [15:0] mul_cnt_q, mul_cnt_d, div_cnt_q, div_cnt_d;

  always_comb begin
    mul_cnt_d = mul_cnt_q;
    div_cnt_d = div_cnt_q;
    if (state_q == ST_FIN && EN) begin
      if (op_q == OP_DIV) div_cnt_d = sat_inc16(div_cnt_q);
      else                mul_cnt_d = sat_inc16(mul_cnt_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mul_cnt_q <= 16'd0;
      div_cnt_q <= 16'd0;
    end else begin
      mul_cnt_q <= mul_cnt_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign MUL_CNT = mul_cnt_q;
  assign DIV_CNT = div_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

  // The datapath reads A/X/Y directly, so the CPU must hold them for the whole operation.
  a_operands_stable: assert property (@(posedge CLK) disable iff (RST)
    (BUSY && $past(BUSY)) |-> $stable({A, X, Y}));

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized scoreboard bench for muldiv_seq with a behavioural SPC700 MUL/DIV datapath.
module tb_muldiv_seq;

  typedef struct {
    logic [15:0] res;
    logic        z, n, v, h;
  } gold_t;

  typedef struct {
    int          lat;
    logic [15:0] res;
    logic [4:0]  fl;
  } exp_t;

  logic clk = 1'b0;
  logic rst, en, start, op;
  logic [7:0] a, x, y;
  logic busy, done, flag_n, flag_z, flag_v, flag_h, vh_we;
  logic [7:0] res_a, res_y;

  muldiv_seq_if md_if ();

  muldiv_seq dut (
    .CLK(clk), .RST(rst), .EN(en), .START(start), .OP(op),
    .A(a), .X(x), .Y(y),
    .MD_EN(md_if.md_en), .MD_SECOP(md_if.md_secop), .MD_RES(md_if.md_res),
    .MD_ZO(md_if.md_zo), .MD_VO(md_if.md_vo), .MD_HO(md_if.md_ho),
    .BUSY(busy), .DONE(done), .RES_A(res_a), .RES_Y(res_y),
    .FLAG_N(flag_n), .FLAG_Z(flag_z), .FLAG_V(flag_v), .FLAG_H(flag_h),
    .FLAG_VH_WE(vh_we)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  logic v_mdl = 1'b0, h_mdl = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // SPC700 arithmetic: MUL YA=Y*A (Z/N from Y); DIV YA/X incl. the hardware overflow path.
  function automatic gold_t ref_op(input bit div, input logic [7:0] ia, ix, iy);
    gold_t g;
    int ya, q, r, m, xi, yi;
    xi = int'(ix);
    yi = int'(iy);
    ya = yi * 256 + int'(ia);
    if (!div) begin
      m     = yi * int'(ia);
      g.res = m[15:0];
      g.z   = (g.res[15:8] == 8'd0);
      g.n   = g.res[15];
      g.v   = 1'b0;
      g.h   = 1'b0;
    end else begin
      if (yi < 2 * xi) begin
        q = ya / xi;
        r = ya % xi;
      end else begin
        q = 255 - (ya - xi * 512) / (256 - xi);
        r = xi + (ya - xi * 512) % (256 - xi);
      end
      g.res = {r[7:0], q[7:0]};
      g.z   = (q[7:0] == 8'd0);
      g.n   = q[7];
      g.v   = (iy >= ix);
      g.h   = (iy[3:0] >= ix[3:0]);
    end
    return g;
  endfunction

  // Datapath model: only presents the true result when the expected number of steps happened.
  logic [7:0] dp_a, dp_x, dp_y;
  logic       dp_div;
  int         dp_steps = 0;
  gold_t      dp_g, h_g;
  logic       dp_ready, ho_ok;

  always @(posedge clk) begin
    if (md_if.md_en) begin
      if (md_if.md_secop == 4'b0000) begin
        dp_a <= a; dp_x <= x; dp_y <= y; dp_div <= op; dp_steps <= 0;
      end else begin
        dp_steps <= dp_steps + 1;
      end
    end
  end

  always_comb begin
    dp_g     = ref_op(dp_div, dp_a, dp_x, dp_y);
    h_g      = ref_op(1'b1, a, x, y);
    dp_ready = (md_if.md_secop == 4'b1110) ? (dp_steps == 7)
             : ((md_if.md_secop == 4'b1111) && (dp_steps == 9));
    ho_ok    = md_if.md_en && (md_if.md_secop == 4'b0000);
    md_if.md_res = dp_ready ? dp_g.res : ~dp_g.res;
    md_if.md_zo  = dp_ready ? dp_g.z : ~dp_g.z;
    md_if.md_vo  = dp_ready ? dp_g.v : ~dp_g.v;
    md_if.md_ho  = ho_ok ? h_g.h : ~h_g.h;
  end

  // Monitor: counts EN edges from START acceptance and checks every DONE against the queue.
  int   cyc = 0;
  logic busy_obs = 1'b0, done_obs = 1'b0;
  logic en_s, st_s, rst_s, b_s;

  always @(posedge clk) begin
    exp_t e;
    en_s = en; st_s = start; rst_s = rst; b_s = busy_obs;
    #1;
    if (rst_s)                     cyc = 0;
    else if (!b_s && st_s && en_s) cyc = 1;
    else if (b_s && en_s)          cyc++;
    if (!rst_s && done && !done_obs) begin
      chk("done_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("latency", cyc, e.lat);
        chk("result", {res_y, res_a}, e.res);
        chk("flags_nzvh_we", {flag_n, flag_z, flag_v, flag_h, vh_we}, e.fl);
      end
    end
    if (!rst_s && done_obs && en_s) chk("done_len", done, 0);
    busy_obs = busy;
    done_obs = done;
  end

  task automatic run_op(input bit div, input logic [7:0] ia, ix, iy,
                        input int mode, input bit hold);
    exp_t  e;
    gold_t g;
    int    rises, falls, guard;
    logic  prev_busy;
    g = ref_op(div, ia, ix, iy);
    if (div) begin v_mdl = g.v; h_mdl = g.h; end
    e.lat = div ? 12 : 10;
    e.res = g.res;
    e.fl  = {g.n, g.z, v_mdl, h_mdl, div};
    exp_q.push_back(e);
    if (hold) exp_q.push_back(e);
    @(negedge clk);
    a = ia; x = ix; y = iy; op = div; start = 1'b1; en = 1'b1;
    rises = 0; falls = 0; guard = 0; prev_busy = busy;
    while (falls < (hold ? 2 : 1) && guard < 400) begin
      @(negedge clk);
      guard++;
      if (busy && !prev_busy) begin
        rises++;
        if (!hold || rises == 2) start = 1'b0;
      end
      if (!busy && prev_busy) falls++;
      prev_busy = busy;
      case (mode)
        1:       en = ~en;
        2:       en = ($urandom_range(0, 3) != 0);
        default: en = 1'b1;
      endcase
    end
    chk("op_complete", falls, hold ? 2 : 1);
    if (hold) chk("hold_two_ops", rises, 2);
    start = 1'b0;
    en    = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0; op = 1'b0; a = 8'd0; x = 8'd0; y = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, done, md_if.md_en, md_if.md_secop, res_a, res_y,
                        flag_n, flag_z, flag_v, flag_h, vh_we}, 0);
    rst = 1'b0;

    run_op(1'b0, 8'h12, 8'h00, 8'h34, 0, 1'b0);
    run_op(1'b1, 8'h34, 8'h56, 8'h12, 0, 1'b0);
    run_op(1'b1, 8'h00, 8'h01, 8'h01, 0, 1'b0);
    run_op(1'b0, 8'h00, 8'h77, 8'hFF, 1, 1'b0);

    // Abort a DIV in its fifth STEP cycle.
    @(negedge clk);
    a = 8'h9A; x = 8'h21; y = 8'h05; op = 1'b1; start = 1'b1; en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_step", {busy, md_if.md_en, md_if.md_secop}, 6'b11_1111);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_op", {busy, done, md_if.md_en, md_if.md_secop, res_a, res_y,
                       flag_n, flag_z, flag_v, flag_h, vh_we}, 0);
    rst = 1'b0; v_mdl = 1'b0; h_mdl = 1'b0;
    run_op(1'b1, 8'h9A, 8'h21, 8'h05, 0, 1'b0);

    run_op(1'b0, 8'h81, 8'h00, 8'hC3, 0, 1'b1);

    for (int i = 0; i < 24; i++)
      run_op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
             $urandom_range(0, 2), 1'b0);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
